// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared state encoding, reset ratio and ratio sanitising for clkdiv_sched
package clkdiv_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_PEND = 2'd2;
   localparam int CLKDIV_DEFAULT_DIV = 3;
   function automatic logic [31:0] sanitize_div(input logic [31:0] d);
      return (d == 32'd0) ? 32'd1 : d;
   endfunction
endpackage

// File: rtl/clkdiv_sched_rr_arb.sv
// rr_arb: NREQ-way round-robin arbiter, one-hot grant, pointer moves past the winner on accept
module rr_arb #(
   parameter int NREQ = 2,
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic [NREQ-1:0] valid,
   output logic [NREQ-1:0] gnt,
   output logic [PW-1:0]   gnt_idx
);
   logic [PW-1:0] ptr_q, ptr_d, sel, idx;
   logic found;
   // Pick the first valid requester at or after the pointer; advance past it when granted.
   always_comb begin
      sel = ptr_q;
      idx = ptr_q;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = PW'((int'(ptr_q) + k) % NREQ);
         if (!found && valid[idx]) begin
            found = 1'b1;
            sel = idx;
         end
      end
      gnt = (found && en) ? NREQ'(1) << sel : '0;
      ptr_d = (found && en) ? ((sel == PW'(NREQ - 1)) ? '0 : sel + PW'(1)) : ptr_q;
   end
   assign gnt_idx = sel;
   // Round-robin pointer register.
   always_ff @(posedge clk) begin
      if (reset) ptr_q <= '0;
      else ptr_q <= ptr_d;
   end
endmodule

// File: rtl/clkdiv_sched.sv
// clkdiv_sched: run-time divider with round-robin ratio updates applied only at half-period boundaries (option: CLKDIV_SCHED_UPDCNT_EN adds upd_cnt)
module clkdiv_sched
   import clkdiv_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int NREQ = 2,
   parameter int DEFAULT_DIV = CLKDIV_DEFAULT_DIV
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run_en,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*CNT_W-1:0] req_div,
   output logic [NREQ-1:0]       req_ready,
   output logic                  div_out,
   output logic                  tick,
   output logic [CNT_W-1:0]      cur_div,
   output logic                  upd_pend
`ifdef CLKDIV_SCHED_UPDCNT_EN
   ,output logic [7:0]           upd_cnt
`endif
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   logic [1:0] state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cur_div_q, cur_div_d, pend_div_q, pend_div_d, new_div;
   logic div_q, div_d, tick_q, tick_d, hs, wrap, counting;
   logic [PW-1:0] gnt_idx;
   rr_arb #(.NREQ(NREQ)) u_arb (
      .clk(clk),
      .reset(reset),
      .en(!reset && state_q != ST_PEND),
      .valid(req_valid),
      .gnt(req_ready),
      .gnt_idx(gnt_idx)
   );
   assign hs = |req_ready;
   assign new_div = CNT_W'(sanitize_div(32'(req_div[gnt_idx*CNT_W +: CNT_W])));
   assign counting = run_en && state_q != ST_IDLE;
   assign wrap = cnt_q == cur_div_q - CNT_W'(1);
   // Next state, counter/toggle, and ratio hand-off; a RUN handshake only ever waits for a later wrap.
   always_comb begin
      state_d = !run_en ? ST_IDLE
              : (state_q == ST_IDLE) ? ST_RUN
              : (state_q == ST_RUN && hs) ? ST_PEND
              : (state_q == ST_PEND && wrap) ? ST_RUN
              : state_q;
      cnt_d = (!counting || wrap) ? '0 : cnt_q + CNT_W'(1);
      div_d = counting && (div_q ^ wrap);
      tick_d = counting && wrap;
      pend_div_d = (state_q == ST_RUN && hs) ? new_div : pend_div_q;
      cur_div_d = (state_q == ST_PEND && (wrap || !run_en)) ? pend_div_q
                : (hs && (state_q == ST_IDLE || !run_en)) ? new_div
                : cur_div_q;
   end
   // Divider and scheduler registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         div_q      <= 1'b0;
         tick_q     <= 1'b0;
         cur_div_q  <= CNT_W'(DEFAULT_DIV);
         pend_div_q <= CNT_W'(DEFAULT_DIV);
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         tick_q     <= tick_d;
         cur_div_q  <= cur_div_d;
         pend_div_q <= pend_div_d;
      end
   end
   assign div_out = div_q;
   assign tick = tick_q;
   assign cur_div = cur_div_q;
   assign upd_pend = state_q == ST_PEND;
`ifdef CLKDIV_SCHED_UPDCNT_EN
   logic [7:0] upd_cnt_q, upd_cnt_d;
   logic applied;
   // Count every ratio written into cur_div, holding at 255.
   always_comb begin
      applied = (hs && (state_q == ST_IDLE || !run_en)) || (state_q == ST_PEND && (wrap || !run_en));
      upd_cnt_d = (applied && upd_cnt_q != 8'hFF) ? upd_cnt_q + 8'd1 : upd_cnt_q;
   end
   // Applied-update counter register.
   always_ff @(posedge clk) begin
      if (reset) upd_cnt_q <= '0;
      else upd_cnt_q <= upd_cnt_d;
   end
   assign upd_cnt = upd_cnt_q;
`endif
endmodule

// File: doc/clkdiv_sched.md
Name: clkdiv_sched

Overview:
- Run-time controller for the team's integer clock divider.
- Owns one shared divider datapath and arbitrates divide-ratio update requests from NREQ requesters using round-robin.
- Applies each accepted ratio only at a half-period boundary, so div_out never produces a runt pulse.
- Sits between software/config agents and any logic that consumes the divided toggle or the tick enable.

Parameters:
- CNT_W, 16: width of the divide ratio and the internal counter.
- NREQ, 2: number of requesters (1..8).
- DEFAULT_DIV, 3: ratio loaded at reset; must be 1..2^CNT_W-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset; clock clk
- run_en  in  1  1 = divider runs; 0 = divider idles
- req_valid  in  NREQ  per-requester update request
- req_div  in  NREQ*CNT_W  requested ratios; requester i uses bits [i*CNT_W +: CNT_W]
- req_ready  out  NREQ  grant; handshake completes on a cycle where valid&ready
- div_out  out  1  divided toggle output; period = 2*cur_div cycles, 50% duty
- tick  out  1  one-cycle pulse on every div_out toggle
- cur_div  out  CNT_W  ratio currently in effect
- upd_pend  out  1  an accepted ratio is waiting for a boundary

Behaviour:
- Reset values: div_out=0, tick=0, cur_div=DEFAULT_DIV, upd_pend=0, counter=0, RR pointer=0, state=IDLE. req_ready is 0 during reset.
- States:
  - IDLE: run_en=0. Counter held at 0, div_out forced 0, tick=0.
  - RUN: counting, no pending update.
  - PEND: counting, pending register holds the next ratio.
- Counting (RUN/PEND):
  - Counter increments each cycle.
  - When counter==cur_div-1: counter wraps to 0, div_out toggles, tick=1 in that same registered cycle.
  - First toggle occurs cur_div cycles after leaving IDLE.
- Arbitration:
  - req_ready is combinational.
  - At most one bit of req_ready is set, and only when no update is pending (state IDLE or RUN).
  - Grant goes to the first valid requester at or after the RR pointer.
  - On a handshake, the pointer moves to the granted index+1, mod NREQ.
  - Requesters must hold valid and data stable until ready.
- Ratio sanitising: req_div==0 is accepted and treated as 1.
- Apply rules:
  - Handshake in IDLE: cur_div updates on the next cycle; no pending state is entered.
  - Handshake in RUN: enter PEND, upd_pend=1 from the next cycle.
  - In PEND, on the wrap cycle: cur_div <= pending value, counter <= 0, upd_pend <= 0, state -> RUN.
  - Handshake in the same cycle as a wrap in RUN: the value waits for the following wrap, not the current one.
- run_en deassert: from any state, go to IDLE next cycle, div_out=0, counter=0. A pending value is applied immediately (cur_div updated, upd_pend cleared).
- run_en assert from IDLE: go to RUN.
- reset mid-operation: returns all state to reset values, including cur_div=DEFAULT_DIV. Any pending update is discarded.
- cur_div==1: div_out toggles every cycle and tick is continuously 1.

Optional Feature:
- Macro CLKDIV_SCHED_UPDCNT_EN.
- When defined:
  - Adds output port upd_cnt (8 bits), a saturating count of ratios actually applied to cur_div (IDLE-direct or at a boundary).
  - The count saturates at 255 and is cleared by reset.
- When undefined: no port and no logic; all other behaviour is identical.

Decomposition:
- Shared package clkdiv_pkg holds:
  - state encoding (IDLE=2'd0, RUN=2'd1, PEND=2'd2);
  - DEFAULT_DIV default;
  - the sanitising rule for a ratio of 0, as a function.
- One natural sub-module: rr_arb, a parameterised NREQ-way round-robin arbiter (valid in, one-hot grant out, pointer advance on accept).

Test Plan:
- Reset release, run_en=1, no requests → first div_out rise at cycle 3, period 6 cycles, tick every 3 cycles, cur_div=3.
- In RUN, requester 0 sends 5 on cycle 1 of a half-period:
  - req_ready[0] is high the same cycle;
  - upd_pend=1 until the next wrap;
  - after that wrap, half-periods are 5 cycles with no half-period shorter than 3.
- Both requesters valid continuously with 4 and 7 → grants alternate 0,1,0,… one per applied update, and req_ready stays 0 while upd_pend=1.
- req_div=0 in IDLE → cur_div=1 next cycle; after run_en=1, div_out toggles every cycle.
- Pending 9 and run_en dropped mid-period → next cycle div_out=0, cur_div=9, upd_pend=0. Synchronous reset mid-PEND → cur_div=3, pending value lost.
- With CLKDIV_SCHED_UPDCNT_EN: 300 applied updates → upd_cnt=255.
